// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU-to-MEM bus interface unit: the controller
// state encoding, the MEM R_W encoding and the default bus widths.
package mem_bus_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   // R_W encoding understood by MEM (the CPU rw input uses the same encoding)
   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      WAIT,
      RELEASE,
      DONE
   } state_e;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Bundle of the CPU request/response signals and the MEM-side signals of the
// bus interface unit. The controller uses the slave modport; the CPU/MEM
// environment uses the master modport.
interface mem_bus_ctrl_if
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   // CPU side
   logic              req;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              done;
   logic              busy;
   logic              err;

   // MEM side
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;
   logic              mem_r_w;
   logic              mem_en;
   logic              mem_mfc;

   modport slave (
      input  req, rw, addr, wdata, mem_data_out, mem_mfc,
      output rdata, done, busy, err, mem_address, mem_data_in, mem_r_w, mem_en
   );

   modport master (
      output req, rw, addr, wdata, mem_data_out, mem_mfc,
      input  rdata, done, busy, err, mem_address, mem_data_in, mem_r_w, mem_en
   );

endinterface

// File: rtl/mfc_sync.sv
// Two-flop synchronizer for an asynchronous handshake input, with a
// registered rising-edge pulse. Reusable for any single-bit async strobe.
module mfc_sync (
   input  logic clk,
   input  logic rst_i,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o
);

   logic s1_q;
   logic s2_q;
   logic rise_q;

   // Resynchronize the input and register the 0->1 transition seen between s1 and s2
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         s1_q   <= async_i;
         s2_q   <= s1_q;
         rise_q <= s1_q & ~s2_q;
      end
   end

   assign sync_o = s2_q;
   assign rise_o = rise_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus interface unit between the CPU control unit and the asynchronous MEM.
// Latches one request into MAR/MDR, presents it to MEM, raises EN after a
// setup period, waits for the synchronized MFC, then releases EN and reports
// completion with a one-cycle done pulse (err on timeout).
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int SETUP_CYC = 1,
   parameter int TIMEOUT   = 15
) (
   input  logic          clk,
   input  logic          reset,
   mem_bus_ctrl_if.slave bus
);

   // The timer is shared by the setup count and the WAIT/RELEASE watchdogs,
   // so it must hold the larger of the two limits.
   localparam int CNT_MAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
   localparam int TW      = $clog2(CNT_MAX + 1);

   localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYC);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMR_MAX    = TW'(CNT_MAX);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;     // MAR
   logic [DATA_W-1:0] wdata_q, wdata_d;   // MDR
   logic              rw_q, rw_d;
   logic              en_q, en_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [TW-1:0]     timer_inc;

   logic              mfc_s2;
   logic              mfc_rise;

   mfc_sync u_mfc_sync (
      .clk     (clk),
      .rst_i   (reset),
      .async_i (bus.mem_mfc),
      .sync_o  (mfc_s2),
      .rise_o  (mfc_rise)
   );

   // Saturating increment: the timer never wraps back to zero
   assign timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;

   // State and output registers; reset aborts any access in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rw_q    <= MEM_READ;
         en_q    <= 1'b0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rw_q    <= rw_d;
         en_q    <= en_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         timer_q <= timer_d;
      end
   end

   // Next-state and next-output logic of the access sequencer
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rw_d    = rw_q;
      en_d    = en_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      err_d   = err_q;
      timer_d = timer_q;

      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               rw_d    = bus.rw;
               err_d   = 1'b0;
               timer_d = '0;
               busy_d  = 1'b1;
               state_d = SETUP;
            end
         end

         SETUP: begin
            // Address/data/R_W have been stable for SETUP_CYC cycles: raise EN
            if (timer_q >= SETUP_LAST) begin
               en_d    = 1'b1;
               timer_d = '0;
               state_d = WAIT;
            end else begin
               timer_d = timer_inc;
            end
         end

         WAIT: begin
            // A completed handshake takes priority over a simultaneous timeout
            if (mfc_rise) begin
               if (rw_q != MEM_WRITE) begin
                  rdata_d = bus.mem_data_out;
               end
               en_d    = 1'b0;
               timer_d = '0;
               state_d = RELEASE;
            end else if (timer_q >= TO_LAST) begin
               en_d    = 1'b0;
               err_d   = 1'b1;
               timer_d = '0;
               state_d = RELEASE;
            end else begin
               timer_d = timer_inc;
            end
         end

         RELEASE: begin
            // Hold EN low until MEM has withdrawn MFC, bounded by the watchdog
            if (!mfc_s2) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else if (timer_q >= TO_LAST) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               timer_d = timer_inc;
            end
         end

         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.mem_address = addr_q;
   assign bus.mem_data_in = wdata_q;
   assign bus.mem_r_w     = rw_q;
   assign bus.mem_en      = en_q;
   assign bus.rdata       = rdata_q;
   assign bus.done        = done_q;
   assign bus.busy        = busy_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: a clocked MEM model answers each EN rising
// edge with MFC after a programmable latency; a reference memory predicts
// the rdata/err of every completed access and the MEM-side view of every
// access; monitors compare the DUT against those queues.
module tb_mem_bus_ctrl;

   localparam int SETUP_CYC = 1;
   localparam int TIMEOUT   = 15;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
   } done_exp_t;

   typedef struct {
      logic [15:0] addr;
      logic        rw;
      logic [15:0] wdata;
      bit          tmo;
   } acc_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mem_bus_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_bus_ctrl #(
      .ADDR_W    (16),
      .DATA_W    (16),
      .SETUP_CYC (SETUP_CYC),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;
   int done_cnt   = 0;
   int en_rises   = 0;

   // Reference model: memory contents and the rdata the CPU should see
   logic [15:0] ref_mem [16];
   logic [15:0] last_rdata;
   done_exp_t   exp_done_q [$];
   acc_exp_t    acc_q [$];

   // MEM model controls and storage
   logic [15:0] mem_arr [16];
   int          mem_lat    = 3;
   bit          mem_noresp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_expect(input logic rw_v, input logic [15:0] a, input logic [15:0] d,
                              input bit nr, input bit abort);
      acc_exp_t  ae;
      done_exp_t de;
      ae.addr  = a;
      ae.rw    = rw_v;
      ae.wdata = d;
      ae.tmo   = nr && !abort;
      acc_q.push_back(ae);
      if (!rw_v) ref_mem[a[3:0]] = d;
      if (!abort) begin
         if (nr) begin
            de.err = 1'b1;
         end else begin
            de.err = 1'b0;
            if (rw_v) last_rdata = ref_mem[a[3:0]];
         end
         de.rdata = last_rdata;
         exp_done_q.push_back(de);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         compared++;
         mismatched++;
         $display("FAIL idle_wait: busy still %b after 200 cycles, required 0", bus.busy);
      end
   endtask

   task automatic wait_en_high();
      int n = 0;
      @(negedge clk);
      while (bus.mem_en !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         compared++;
         mismatched++;
         $display("FAIL en_wait: mem_en still %b after 50 cycles, required 1", bus.mem_en);
      end
   endtask

   // Present one request from IDLE, then scramble the CPU inputs while busy
   task automatic issue(input logic rw_v, input logic [15:0] a, input logic [15:0] d,
                        input int lat, input bit nr, input bit abort);
      wait_idle();
      mem_lat    = lat;
      mem_noresp = nr;
      bus.req    = 1'b1;
      bus.rw     = rw_v;
      bus.addr   = a;
      bus.wdata  = d;
      push_expect(rw_v, a, d, nr, abort);
      @(posedge clk);
      #1;
      bus.req   = 1'b0;
      bus.rw    = 1'($urandom_range(0, 1));
      bus.addr  = 16'($urandom);
      bus.wdata = 16'($urandom);
   endtask

   // MEM model: acts on the EN rising edge, raises MFC after mem_lat cycles,
   // withdraws MFC once EN is seen low
   initial begin
      logic [15:0] ma;
      logic [15:0] md;
      logic        mrw;
      bit          active;
      bit          nr;
      bit          en_prev;
      int          cnt;
      int          lat;
      for (int i = 0; i < 16; i++) mem_arr[i] = 16'h0;
      mem_arr[0]       = 16'd4;
      bus.mem_mfc      = 1'b0;
      bus.mem_data_out = 16'h0;
      active  = 1'b0;
      en_prev = 1'b0;
      nr      = 1'b0;
      cnt     = 0;
      lat     = 0;
      ma      = '0;
      md      = '0;
      mrw     = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            bus.mem_mfc = 1'b0;
            active      = 1'b0;
            en_prev     = 1'b0;
            continue;
         end
         if (!bus.mem_en) bus.mem_mfc = 1'b0;
         if (bus.mem_en && !en_prev) begin
            ma     = bus.mem_address;
            md     = bus.mem_data_in;
            mrw    = bus.mem_r_w;
            lat    = mem_lat;
            nr     = mem_noresp;
            cnt    = 0;
            active = 1'b1;
            if (!mrw) mem_arr[ma[3:0]] = md;
         end
         en_prev = bus.mem_en;
         if (active) begin
            cnt++;
            if (cnt >= lat && !nr) begin
               if (mrw) bus.mem_data_out = mem_arr[ma[3:0]];
               bus.mem_mfc = 1'b1;
               active      = 1'b0;
            end
         end
      end
   end

   // Completion monitor: every done pulse is matched against the next expectation
   initial begin
      done_exp_t de;
      bit        done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            done_prev = 1'b0;
            continue;
         end
         if (done_prev) check("busy_after_done", bus.busy, 1'b0);
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_prev) check("done_width", 2, 1);
            check("busy_at_done", bus.busy, 1'b1);
            check("en_low_at_done", bus.mem_en, 1'b0);
            if (exp_done_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               de = exp_done_q.pop_front();
               check("rdata", bus.rdata, de.rdata);
               check("err", bus.err, de.err);
            end
            $display("txn %0d: rw=%b addr=%h rdata=%h err=%b", done_cnt, bus.mem_r_w,
                     bus.mem_address, bus.rdata, bus.err);
         end
         done_prev = bus.done;
      end
   end

   // MEM-side monitor: address/R_W/data at EN rise, stability, EN timing
   initial begin
      acc_exp_t cur;
      bit       en_prev   = 1'b0;
      bit       busy_prev = 1'b0;
      bit       moved     = 1'b0;
      int       en_len    = 0;
      int       gap       = 100;
      int       since     = 0;
      cur.addr  = '0;
      cur.rw    = 1'b1;
      cur.wdata = '0;
      cur.tmo   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            en_prev   = 1'b0;
            busy_prev = 1'b0;
            en_len    = 0;
            gap       = 100;
            since     = 0;
            continue;
         end
         if (bus.busy && !busy_prev) since = 0;
         else since++;
         busy_prev = bus.busy;
         if (bus.mem_en) begin
            if (!en_prev) begin
               en_rises++;
               check("en_low_gap_ok", (gap >= 2) ? 1 : 0, 1);
               check("setup_latency", since, SETUP_CYC + 1);
               if (acc_q.size() == 0) begin
                  check("unexpected_access", 1, 0);
                  cur.addr  = bus.mem_address;
                  cur.rw    = bus.mem_r_w;
                  cur.wdata = bus.mem_data_in;
                  cur.tmo   = 1'b0;
               end else begin
                  cur = acc_q.pop_front();
                  check("mem_address", bus.mem_address, cur.addr);
                  check("mem_r_w", bus.mem_r_w, cur.rw);
                  if (!cur.rw) check("mem_data_in", bus.mem_data_in, cur.wdata);
               end
               en_len = 0;
               moved  = 1'b0;
            end
            if (bus.mem_address !== cur.addr || bus.mem_r_w !== cur.rw ||
                (!cur.rw && bus.mem_data_in !== cur.wdata)) moved = 1'b1;
            en_len++;
         end else begin
            if (en_prev) begin
               check("mem_bus_stable", moved, 1'b0);
               if (cur.tmo) check("en_high_cycles", en_len, TIMEOUT);
               gap = 0;
            end
            gap++;
         end
         en_prev = bus.mem_en;
      end
   end

   // Stimulus
   initial begin
      int n0;
      int r0;
      logic        rw_v;
      logic [15:0] a;
      logic [15:0] d;
      bit          nr;
      bus.req   = 1'b0;
      bus.rw    = 1'b1;
      bus.addr  = '0;
      bus.wdata = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;
      ref_mem[0] = 16'd4;
      last_rdata = 16'h0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_mem_en", bus.mem_en, 1'b0);
      check("reset_mem_r_w", bus.mem_r_w, 1'b1);
      check("reset_mem_address", bus.mem_address, 16'h0);
      check("reset_mem_data_in", bus.mem_data_in, 16'h0);
      check("reset_rdata", bus.rdata, 16'h0);
      check("reset_done", bus.done, 1'b0);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_err", bus.err, 1'b0);
      #2 rst = 1'b0;

      // Read of mem[0] with MFC three cycles after EN
      issue(1'b1, 16'd0, 16'h0, 3, 1'b0, 1'b0);

      // Write then read back
      issue(1'b0, 16'd3, 16'hBEEF, 3, 1'b0, 1'b0);
      issue(1'b1, 16'd3, 16'h0, 3, 1'b0, 1'b0);

      // Timeout, then a good access clears err
      issue(1'b1, 16'd1, 16'h0, 3, 1'b1, 1'b0);
      issue(1'b1, 16'd0, 16'h0, 3, 1'b0, 1'b0);

      // req pulsed while busy is ignored
      wait_idle();
      n0 = done_cnt;
      r0 = en_rises;
      issue(1'b1, 16'd2, 16'h0, 6, 1'b0, 1'b0);
      wait_en_high();
      @(negedge clk);
      bus.req   = 1'b1;
      bus.addr  = 16'd5;
      bus.rw    = 1'b0;
      bus.wdata = 16'h1234;
      @(negedge clk);
      bus.req = 1'b0;
      wait_idle();
      check("reject_done_count", done_cnt - n0, 1);
      check("reject_access_count", en_rises - r0, 1);

      // Asynchronous reset in the middle of WAIT
      issue(1'b1, 16'd2, 16'h0, 3, 1'b1, 1'b1);
      wait_en_high();
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_mem_en", bus.mem_en, 1'b0);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_rdata", bus.rdata, 16'h0);
      last_rdata = 16'h0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      issue(1'b1, 16'd0, 16'h0, 3, 1'b0, 1'b0);

      // req held high across two reads; address change while busy is ignored
      wait_idle();
      r0 = en_rises;
      mem_lat    = 2;
      mem_noresp = 1'b0;
      bus.req    = 1'b1;
      bus.rw     = 1'b1;
      bus.addr   = 16'd0;
      push_expect(1'b1, 16'd0, 16'h0, 1'b0, 1'b0);
      push_expect(1'b1, 16'd1, 16'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1 bus.addr = 16'd1;
      wait_idle();
      @(posedge clk);
      #1 bus.req = 1'b0;
      wait_idle();
      check("held_req_accesses", en_rises - r0, 2);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         rw_v = 1'($urandom_range(0, 1));
         a    = 16'($urandom);
         d    = 16'($urandom);
         nr   = rw_v && ($urandom_range(0, 7) == 0);
         issue(rw_v, a, d, $urandom_range(1, 6), nr, 1'b0);
      end

      wait_idle();
      repeat (4) @(negedge clk);
      check("pending_done_expectations", exp_done_q.size(), 0);
      check("pending_access_expectations", acc_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Bus interface unit between the CPU control unit and the asynchronous MEM block.
- Latches each CPU load/store request into internal MAR/MDR registers, drives MEM's address/dataIn/R_W/EN, and waits for the MFC handshake.
- Captures read data and returns a one-cycle done pulse, with a timeout error if MFC never arrives.
- Fully synchronous on the CPU side. MFC is treated as asynchronous and is synchronized internally.

Parameters:
- ADDR_W, 16, width of address bus.
- DATA_W, 16, width of data buses.
- SETUP_CYC, 1, cycles the address/data/R_W are held stable before EN rises (minimum 1).
- TIMEOUT, 15, max cycles spent in WAIT or in RELEASE before the access is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  CPU access request, sampled only in IDLE.
- rw  in  1  1 = read, 0 = write (same encoding as MEM R_W).
- addr  in  ADDR_W  CPU address.
- wdata  in  DATA_W  CPU write data.
- rdata  out  DATA_W  read result, held until the next read completes.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the accept cycle+1 through the done cycle.
- err  out  1  timeout flag; set with done, cleared on the next accept.
- mem_address  out  ADDR_W  to MEM address.
- mem_data_in  out  DATA_W  to MEM dataIn.
- mem_data_out  in  DATA_W  from MEM dataOut.
- mem_r_w  out  1  to MEM R_W.
- mem_en  out  1  to MEM EN.
- mem_mfc  in  1  from MEM MFC (asynchronous).

Behaviour:
- Reset (async, immediate): state IDLE, mem_en=0, mem_r_w=1, mem_address=0, mem_data_in=0, rdata=0, done=0, busy=0, err=0, timer=0, sync flops=0.
- All outputs are registered. mem_en never glitches.
- MFC path: 2-flop synchronizer (s1, s2) plus edge detect. mfc_rise = s1 & ~s2 (registered). Synchronizer latency is 2 cycles.
- IDLE:
  - If req=1: latch addr→mem_address, wdata→mem_data_in, rw→mem_r_w.
  - Clear err and timer; go to SETUP.
  - If req=0: hold.
- SETUP: count SETUP_CYC cycles, then set mem_en=1, clear timer, go to WAIT. mem_en therefore rises SETUP_CYC+1 cycles after the accept edge.
- WAIT: timer increments each cycle.
  - On mfc_rise: if mem_r_w=1, capture mem_data_out→rdata (MEM drives dataOut before raising MFC). Then mem_en=0, timer=0, go to RELEASE.
  - If timer==TIMEOUT-1 with no mfc_rise: mem_en=0, err=1, timer=0, go to RELEASE. mem_en is high exactly TIMEOUT cycles. rdata is unchanged.
  - If mfc_rise and timeout coincide, mfc_rise wins (no err).
- RELEASE:
  - Wait for synchronized MFC (s2)=0, then go to DONE.
  - If timer reaches TIMEOUT-1 first, set err=1 and go to DONE.
  - Guarantees mem_en stays low for at least 1 cycle between accesses, because MEM only acts on the EN rising edge.
- DONE: done=1 for exactly one cycle, busy=0 on the next cycle, go to IDLE.
- A req held high re-accepts in IDLE on the cycle after DONE. Back-to-back accesses therefore have an EN low gap of at least 2 cycles.
- req while busy is ignored, not queued. A change on addr/wdata/rw while busy has no effect on the mem_* outputs.
- mem_address, mem_data_in and mem_r_w stay stable from SETUP through RELEASE.
- Reset mid-access aborts: mem_en drops asynchronously, no done pulse is issued, and rdata returns to 0.
- Timer width: $clog2(TIMEOUT+1). Counting saturates and never wraps.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding: IDLE, SETUP, WAIT, RELEASE, DONE;
  - constants MEM_READ=1'b1 and MEM_WRITE=1'b0;
  - default ADDR_W/DATA_W.
- One sub-module: mfc_sync, containing the 2-flop synchronizer with registered rising-edge output. It is reset to 0 asynchronously and will be reused for other async handshake inputs.

Test Plan:
- Read after MEM reset (mem[0]=4), clocked MEM model raising MFC 3 cycles after EN: req, rw=1, addr=0 → rdata=16'd4, single done pulse, err=0, mem_en low before done.
- Write then read: write addr=3 data=16'hBEEF, then read addr=3 → rdata=16'hBEEF; mem_en low for at least 2 cycles between the two EN pulses.
- Timeout: MEM model never raises MFC, TIMEOUT=15 → mem_en high exactly 15 cycles, err=1 with done, rdata unchanged; next successful access clears err.
- Busy rejection: during WAIT of a read at addr=2, pulse req with addr=5 → mem_address stays 2, exactly one done pulse, no second access.
- Async reset mid-WAIT: assert reset between clock edges → mem_en=0 and busy=0 before the next edge, no done pulse; subsequent read of addr=0 returns 16'd4.
- req held high across two accesses (read addr=0, then read addr=1) → two done pulses, two distinct EN rising edges, rdata=4 then 0.
